// File: rtl/rf_pkg.sv
// Shared defaults and types for the architectural register file.
// Counter width follows the deepest number of in-flight writes.
package rf_pkg;

    localparam int DEF_DATA_W       = 32;
    localparam int DEF_ADDR_W       = 5;
    localparam int DEF_MAX_INFLIGHT = 3;
    localparam int REG_ZERO         = 0;
    localparam int CNT_W            = $clog2(DEF_MAX_INFLIGHT + 1);

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/pending_counter.sv
// Saturating up/down counter of outstanding writes to one register.
// ovf/unf flag a blocked step; the count never wraps.
module pending_counter
    import rf_pkg::*;
#(
    parameter int MAX = DEF_MAX_INFLIGHT,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          ovf,
    output logic          unf
);

    assign ovf = inc & ~dec & (cnt == CW'(MAX));
    assign unf = dec & ~inc & (cnt == '0);

    // Count up on issue, down on write-back; simultaneous events cancel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc & ~dec & ~ovf) begin
            cnt <= cnt + CW'(1);
        end else if (dec & ~inc & ~unf) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/register_file.sv
// Register file with write-back bypass and per-register pending-write
// scoreboard driving a read-after-write hazard to decode.
module register_file
    import rf_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    input  logic              src2_valid,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic              hazard,
    output logic              err
);

    localparam int NREG = 2 ** ADDR_W;
    localparam int CW   = $clog2(MAX_INFLIGHT + 1);
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem [NREG];
    logic [CW-1:0]     cnt [NREG];
    logic [NREG-1:0]   ovf;
    logic [NREG-1:0]   unf;
    logic              busy1;
    logic              busy2;
    logic              err_q;

    // Architectural state; r0 is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wb_en && wb_dest != ZERO) begin
            mem[wb_dest] <= wb_value;
        end
    end

    // Read ports: r0 is hardwired zero, a same-cycle write is forwarded.
    always_comb begin
        reg1 = mem[src1];
        reg2 = mem[src2];
        if (wb_en && wb_dest == src1) begin
            reg1 = wb_value;
        end
        if (wb_en && wb_dest == src2) begin
            reg2 = wb_value;
        end
        if (src1 == ZERO) begin
            reg1 = '0;
        end
        if (src2 == ZERO) begin
            reg2 = '0;
        end
    end

    // A single pending write that retires this cycle is covered by bypass.
    assign busy1 = (src1 != ZERO) && (cnt[src1] != '0) &&
                   !(cnt[src1] == CW'(1) && wb_en && wb_dest == src1);
    assign busy2 = (src2 != ZERO) && (cnt[src2] != '0) &&
                   !(cnt[src2] == CW'(1) && wb_en && wb_dest == src2);
    assign hazard = busy1 | (src2_valid & busy2);

    assign cnt[0] = '0;
    assign ovf[0] = 1'b0;
    assign unf[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        logic inc;
        logic dec;
        assign inc = issue_en & ~hazard & (issue_dest == ADDR_W'(i));
        assign dec = wb_en & (wb_dest == ADDR_W'(i));
        pending_counter #(
            .MAX (MAX_INFLIGHT),
            .CW  (CW)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (inc),
            .dec (dec),
            .cnt (cnt[i]),
            .ovf (ovf[i]),
            .unf (unf[i])
        );
    end

    // Sticky scoreboard error, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if ((|ovf) | (|unf)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: directed vectors queue expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  src1 = '0;
    logic [4:0]  src2 = '0;
    logic        src2_valid = 1'b0;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_dest = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_dest = '0;
    logic [31:0] wb_value = '0;
    logic        hazard;
    logic        err;

    typedef struct {
        string       nm;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        h;
        logic        e;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    register_file dut (
        .clk        (clk),
        .rst        (rst),
        .src1       (src1),
        .src2       (src2),
        .src2_valid (src2_valid),
        .reg1       (reg1),
        .reg2       (reg2),
        .issue_en   (issue_en),
        .issue_dest (issue_dest),
        .wb_en      (wb_en),
        .wb_dest    (wb_dest),
        .wb_value   (wb_value),
        .hazard     (hazard),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() != 0) begin
            cur = q.pop_front();
            checks++;
            if ({reg1, reg2, hazard, err} !== {cur.r1, cur.r2, cur.h, cur.e}) begin
                errors++;
                $display("FAIL %s: got reg1=%h reg2=%h hazard=%b err=%b, expected reg1=%h reg2=%h hazard=%b err=%b",
                         cur.nm, reg1, reg2, hazard, err, cur.r1, cur.r2, cur.h, cur.e);
            end
        end
    end

    task automatic vec(
        input string       nm,
        input logic        r,
        input logic [4:0]  s1,
        input logic [4:0]  s2,
        input logic        s2v,
        input logic        ie,
        input logic [4:0]  id,
        input logic        we,
        input logic [4:0]  wd,
        input logic [31:0] wv,
        input logic [31:0] e1,
        input logic [31:0] e2,
        input logic        eh,
        input logic        ee
    );
        exp_t x;
        rst        = r;
        src1       = s1;
        src2       = s2;
        src2_valid = s2v;
        issue_en   = ie;
        issue_dest = id;
        wb_en      = we;
        wb_dest    = wd;
        wb_value   = wv;
        x.nm = nm;
        x.r1 = e1;
        x.r2 = e2;
        x.h  = eh;
        x.e  = ee;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        //   name           rst s1  s2 s2v ie id  we wd  wv            reg1          reg2          h  e
        vec("reset_hold",   0,  5, 31, 1,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
        vec("rst_release",  1,  5, 31, 1,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
        vec("issue7",       1,  0,  0, 0,  1, 7,  0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
        vec("bypass",       1,  7,  0, 0,  0, 0,  1, 7,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0, 0);
        vec("mem_read",     1,  7,  7, 1,  0, 0,  0, 0,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        vec("r0_write",     1,  0,  0, 1,  0, 0,  1, 0,  32'h1234,     32'h0,        32'h0,        0, 0);
        vec("r0_issue",     1,  0,  0, 1,  1, 0,  0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
        vec("r0_after",     1,  0,  0, 1,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
        vec("issue3",       1,  0,  0, 0,  1, 3,  0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
        vec("raw_c1",       1,  3,  0, 0,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0,        1, 0);
        vec("raw_c2",       1,  3,  0, 0,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0,        1, 0);
        vec("raw_wb",       1,  3,  0, 0,  0, 0,  1, 3,  32'h55,       32'h55,       32'h0,        0, 0);
        vec("issue3b",      1,  0,  0, 0,  1, 3,  0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
        vec("src2_gated",   1,  0,  3, 0,  0, 0,  0, 0,  32'h0,        32'h0,        32'h55,       0, 0);
        vec("src2_valid",   1,  0,  3, 1,  0, 0,  0, 0,  32'h0,        32'h0,        32'h55,       1, 0);
        vec("src2_wb",      1,  0,  3, 0,  0, 0,  1, 3,  32'h66,       32'h0,        32'h66,       0, 0);
        vec("issue4a",      1,  0,  0, 0,  1, 4,  0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
        vec("issue4b",      1,  0,  0, 0,  1, 4,  0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
        vec("dbl_wait",     1,  4,  0, 0,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0,        1, 0);
        vec("dbl_wb1",      1,  4,  0, 0,  0, 0,  1, 4,  32'hA1,       32'hA1,       32'h0,        1, 0);
        vec("dbl_wb2",      1,  4,  0, 0,  0, 0,  1, 4,  32'hA2,       32'hA2,       32'h0,        0, 0);
        vec("issue4c",      1,  0,  0, 0,  1, 4,  0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
        vec("inc_dec",      1,  0,  0, 0,  1, 4,  1, 4,  32'hA3,       32'h0,        32'h0,        0, 0);
        vec("cnt_kept",     1,  4,  0, 0,  0, 0,  0, 0,  32'h0,        32'hA3,       32'h0,        1, 0);
        vec("cnt_kept_wb",  1,  4,  0, 0,  0, 0,  1, 4,  32'hA4,       32'hA4,       32'h0,        0, 0);
        vec("cnt_zero",     1,  4,  0, 0,  0, 0,  0, 0,  32'h0,        32'hA4,       32'h0,        0, 0);
        vec("ovf_issue1",   1,  1,  1, 1,  1, 9,  0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
        vec("ovf_issue2",   1,  1,  1, 1,  1, 9,  0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
        vec("ovf_issue3",   1,  1,  1, 1,  1, 9,  0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
        vec("ovf_issue4",   1,  1,  1, 1,  1, 9,  0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
        vec("ovf_err",      1,  9,  0, 0,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0,        1, 1);
        vec("async_rst",    0,  4,  7, 1,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
        vec("post_rst",     1,  9,  4, 1,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0,        0, 0);
        vec("unf_wb",       1, 10,  0, 0,  0, 0,  1, 10, 32'h77,       32'h77,       32'h0,        0, 0);
        vec("unf_err",      1, 10,  0, 0,  0, 0,  0, 0,  32'h0,        32'h77,       32'h0,        0, 1);
        vec("issue5",       1,  0,  0, 0,  1, 5,  0, 0,  32'h0,        32'h0,        32'h0,        0, 1);
        vec("drop_issue",   1,  5,  0, 0,  1, 6,  0, 0,  32'h0,        32'h0,        32'h0,        1, 1);
        vec("drop_chk",     1,  6,  0, 0,  0, 0,  0, 0,  32'h0,        32'h0,        32'h0,        0, 1);
        @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule
